// File: rtl/my_arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM encoding,
// operation mode constants, debug view and a parameter sanity check.
package my_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Debug view of the sequencer, exported so checkers can bind to it.
  typedef struct packed {
    state_t state;
    logic   sub;
  } dbg_t;

  // True when DIGIT is a legal slice width for WIDTH.
  function automatic bit width_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/my_add_digit.sv
// One-bit full adder cell and the DIGIT-wide ripple adder built from it.
// The ripple adder is purely combinational; the caller registers the carry.
module my_fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Classic sum/majority equations.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

module my_add_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             carry_into_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    my_fulladder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout           = c[DIGIT];
  assign carry_into_msb = c[DIGIT-1];

endmodule

// File: rtl/my_add_serial.sv
// Digit-serial adder/subtractor. Operands are latched on accept, then
// consumed DIGIT bits per cycle LSB-first with a registered carry. The
// finished result is held in separate output registers so a new operation
// never exposes partial sums.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid must then stay asserted with stable payload until that
// edge, and ready may depend on state only (never combinationally on valid).
import my_arith_pkg::*;

module my_add_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output dbg_t             dbg
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_param
    $error("my_add_serial: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic             carry_r;
  logic             sub_r;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [DIGIT-1:0] sl_sum;
  logic             sl_cout;
  logic             sl_cmsb;

  // Operand registers shift right, so the active slice is always the low DIGIT bits.
  my_add_digit #(.DIGIT(DIGIT)) u_digit (
    .a              (a_r[DIGIT-1:0]),
    .b              (b_r[DIGIT-1:0]),
    .cin            (carry_r),
    .sum            (sl_sum),
    .cout           (sl_cout),
    .carry_into_msb (sl_cmsb)
  );

  assign last      = (cnt == CW'(N - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg.state = state;
  assign dbg.sub   = sub_r;

  // Result assembly: each new slice enters at the top and earlier slices move down.
  always_comb begin
    acc_nx = (acc >> DIGIT) | (WIDTH'(sl_sum) << (WIDTH - DIGIT));
  end

  // Next-state logic for the accept / run / hold sequence.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      carry_r  <= 1'b0;
      sub_r    <= 1'b0;
      cnt      <= '0;
      out      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract is a + ~b + 1, with the borrow-in folded into the carry.
            a_r     <= a;
            b_r     <= (sub == OP_ADD) ? b : ~b;
            carry_r <= (sub == OP_SUB) ? ~cin : cin;
            sub_r   <= sub;
            cnt     <= '0;
          end
        end
        RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          acc     <= acc_nx;
          carry_r <= sl_cout;
          cnt     <= cnt + CW'(1);
          if (last) begin
            out      <= acc_nx;
            cout     <= sl_cout;
            // Carry into the MSB differing from carry out of it is the same
            // condition as equal operand signs with a differing result sign.
            overflow <= sl_cout ^ sl_cmsb;
            zero     <= (acc_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
